// File: rtl/cv32e40p_apu_core_pkg.sv
// APU interface widths shared by cores, FPU and the APU arbiter.
// Also holds the arbiter limits and the requester-ID type.
package cv32e40p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  localparam int APU_ARB_MAX_REQ  = 8;
  localparam int APU_ARB_ID_W     = $clog2(APU_ARB_MAX_REQ);

  typedef logic [APU_ARB_ID_W-1:0] apu_arb_id_t;

endpackage

// File: rtl/cv32e40p_apu_arb_id_fifo.sv
// Requester-ID FIFO: records who issued each in-flight APU op.
// Ports: clk, rst (sync, high), push/din, pop, full, empty, head.
module cv32e40p_apu_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign head    = mem[rd_q];
  assign push_ok = push & ~full & ~rst;
  assign pop_ok  = pop & ~empty & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= din;
  end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin share of one APU/FPU between NUM_REQ cores.
// Ports: core_* (per-core APU side), apu_* (FPU side), err_o,
// perf_stall_cnt_o. Stall counters built only when
// CV32E40P_APU_ARB_PERF_EN is defined, else tied to zero.
module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [NUM_REQ-1:0] core_req_i,
  output logic [NUM_REQ-1:0] core_gnt_o,
  input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0]
         core_operands_i,
  input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0] core_op_i,
  input  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]
         core_flags_i,
  output logic [NUM_REQ-1:0] core_rvalid_o,
  output logic [31:0] core_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0] core_rflags_o,
  output logic apu_req_o,
  input  logic apu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0] apu_operands_o,
  output logic [APU_WOP_CPU-1:0] apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0] apu_flags_o,
  input  logic apu_rvalid_i,
  input  logic [31:0] apu_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0] apu_rflags_i,
  output logic err_o,
  output logic [NUM_REQ-1:0][31:0] perf_stall_cnt_o
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    off;
  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    mux_idx;
  logic [ID_W-1:0]    head;
  logic [NUM_REQ-1:0] rot;
  logic [ID_W:0]      sum;
  logic [ID_W:0]      nxt;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Rotate so bit 0 is the pointer's core; first set bit wins.
  assign rot = (core_req_i >> ptr)
             | (core_req_i << (NREQ - {1'b0, ptr}));

  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, off};
  assign sel = (sum >= NREQ) ? ID_W'(sum - NREQ)
                             : sum[ID_W-1:0];
  assign nxt = {1'b0, sel} + (ID_W+1)'(1);

  // Full is judged on registered state, so a same-cycle pop
  // never lets an extra op through.
  assign apu_req_o = ~rst_i & ~full & (|core_req_i);
  assign push      = apu_req_o & apu_gnt_i;
  assign pop       = ~rst_i & apu_rvalid_i & ~empty;

  assign mux_idx        = apu_req_o ? sel : ptr;
  assign apu_operands_o = core_operands_i[mux_idx];
  assign apu_op_o       = core_op_i[mux_idx];
  assign apu_flags_o    = core_flags_i[mux_idx];

  assign core_result_o = apu_result_i;
  assign core_rflags_o = apu_rflags_i;

  always_comb begin
    core_gnt_o    = '0;
    core_rvalid_o = '0;
    if (push) core_gnt_o[sel]     = 1'b1;
    if (pop)  core_rvalid_o[head] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr   <= '0;
      err_o <= 1'b0;
    end else begin
      if (push) begin
        ptr <= (nxt == NREQ) ? '0 : nxt[ID_W-1:0];
      end
      if (apu_rvalid_i && empty) err_o <= 1'b1;
    end
  end

  cv32e40p_apu_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef CV32E40P_APU_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (core_req_i[i] && !core_gnt_o[i]
            && stall_q[i] != 32'hFFFF_FFFF) begin
          stall_q[i] <= stall_q[i] + 32'd1;
        end
      end
    end
  end

  assign perf_stall_cnt_o = stall_q;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Testbench for cv32e40p_apu_arbiter: directed scenarios and
// random traffic compared against a queue-based model.
module tb_cv32e40p_apu_arbiter;
  import cv32e40p_apu_core_pkg::*;

  localparam int N = 2;
  localparam int D = 4;

  logic clk;
  logic rst_i;
  logic [N-1:0] core_req_i;
  logic [N-1:0] core_gnt_o;
  logic [N-1:0][APU_NARGS_CPU-1:0][31:0] core_operands_i;
  logic [N-1:0][APU_WOP_CPU-1:0] core_op_i;
  logic [N-1:0][APU_NDSFLAGS_CPU-1:0] core_flags_i;
  logic [N-1:0] core_rvalid_o;
  logic [31:0] core_result_o;
  logic [APU_NUSFLAGS_CPU-1:0] core_rflags_o;
  logic apu_req_o;
  logic apu_gnt_i;
  logic [APU_NARGS_CPU-1:0][31:0] apu_operands_o;
  logic [APU_WOP_CPU-1:0] apu_op_o;
  logic [APU_NDSFLAGS_CPU-1:0] apu_flags_o;
  logic apu_rvalid_i;
  logic [31:0] apu_result_i;
  logic [APU_NUSFLAGS_CPU-1:0] apu_rflags_i;
  logic err_o;
  logic [N-1:0][31:0] perf_stall_cnt_o;

  cv32e40p_apu_arbiter #(
    .NUM_REQ (N),
    .MAX_OUTSTANDING (D)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .core_req_i (core_req_i),
    .core_gnt_o (core_gnt_o),
    .core_operands_i (core_operands_i),
    .core_op_i (core_op_i),
    .core_flags_i (core_flags_i),
    .core_rvalid_o (core_rvalid_o),
    .core_result_o (core_result_o),
    .core_rflags_o (core_rflags_o),
    .apu_req_o (apu_req_o),
    .apu_gnt_i (apu_gnt_i),
    .apu_operands_o (apu_operands_o),
    .apu_op_o (apu_op_o),
    .apu_flags_o (apu_flags_o),
    .apu_rvalid_i (apu_rvalid_i),
    .apu_result_i (apu_result_i),
    .apu_rflags_i (apu_rflags_i),
    .err_o (err_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int ptr_m;
  int q_m[$];
  bit err_m;
  longint perf_m[N];
  logic [N-1:0] egnt_last;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ptr_m = 0;
    q_m.delete();
    err_m = 1'b0;
    for (int i = 0; i < N; i++) perf_m[i] = 0;
  endtask

  task automatic step(input bit r,
                      input logic [N-1:0] req,
                      input bit g,
                      input bit rv,
                      input logic [31:0] res,
                      input logic [4:0] rf);
    int sel_m;
    bit ereq;
    logic [N-1:0] egnt;
    logic [N-1:0] erv;
    longint eperf;
    rst_i = r;
    core_req_i = req;
    apu_gnt_i = g;
    apu_rvalid_i = rv;
    apu_result_i = res;
    apu_rflags_i = rf;
    #3;
    ereq = !r && q_m.size() < D && req != '0;
    sel_m = ptr_m;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr_m + k) % N;
      if (req[c]) begin
        sel_m = c;
        break;
      end
    end
    egnt = (ereq && g) ? (N'(1) << sel_m) : '0;
    erv = (!r && rv && q_m.size() > 0)
        ? (N'(1) << q_m[0]) : '0;
    check("apu_req", apu_req_o, ereq);
    check("core_gnt", core_gnt_o, egnt);
    check("core_rvalid", core_rvalid_o, erv);
    check("result", core_result_o, res);
    check("rflags", core_rflags_o, rf);
    check("err", err_o, err_m);
    if (ereq) begin
      check("apu_op", apu_op_o, core_op_i[sel_m]);
      check("apu_operands", apu_operands_o,
            core_operands_i[sel_m]);
      check("apu_flags", apu_flags_o, core_flags_i[sel_m]);
    end
    for (int i = 0; i < N; i++) begin
`ifdef CV32E40P_APU_ARB_PERF_EN
      eperf = perf_m[i];
`else
      eperf = 0;
`endif
      check($sformatf("perf%0d", i), perf_stall_cnt_o[i],
            128'(eperf));
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && !egnt[i] && perf_m[i] < 64'hFFFF_FFFF)
          perf_m[i]++;
      end
      if (rv) begin
        if (q_m.size() > 0) void'(q_m.pop_front());
        else err_m = 1'b1;
      end
      if (egnt != '0) begin
        q_m.push_back(sel_m);
        ptr_m = (sel_m + 1) % N;
      end
    end
    egnt_last = egnt;
    #1;
  endtask

  task automatic new_payload(input int i);
    core_op_i[i] = APU_WOP_CPU'($urandom);
    core_operands_i[i] = {$urandom, $urandom, $urandom};
    core_flags_i[i] = APU_NDSFLAGS_CPU'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * D && q_m.size() > 0; k++)
      step(0, '0, 0, 1, $urandom, 5'($urandom));
  endtask

  logic [N-1:0] pend;

  initial begin
    rst_i = 1'b1;
    core_req_i = '0;
    apu_gnt_i = 1'b0;
    apu_rvalid_i = 1'b0;
    apu_result_i = '0;
    apu_rflags_i = '0;
    core_op_i[0] = 6'h0A;
    core_op_i[1] = 6'h15;
    core_operands_i[0] = {32'h1, 32'h2, 32'h3};
    core_operands_i[1] = {32'hA, 32'hB, 32'hC};
    core_flags_i[0] = 15'h0111;
    core_flags_i[1] = 15'h7222;
    @(posedge clk);
    #1;
    model_reset();
    step(1, 2'b11, 1, 1, 32'h0, 5'h0);

    // single core issue and response
    step(0, 2'b01, 1, 0, 32'h0, 5'h0);
    step(0, 2'b00, 0, 0, 32'h0, 5'h0);
    step(0, 2'b00, 0, 1, 32'h3F80_0000, 5'h01);

    // fairness, then full blocking with same-cycle pop
    step(1, 2'b00, 0, 0, 32'h0, 5'h0);
    for (int k = 0; k < 4; k++)
      step(0, 2'b11, 1, 0, 32'h0, 5'h0);
    step(0, 2'b11, 1, 0, 32'h0, 5'h0);
    step(0, 2'b11, 1, 1, 32'h1111, 5'h02);
    step(0, 2'b11, 1, 0, 32'h0, 5'h0);
    drain();

    // backpressure on core1
    for (int k = 0; k < 3; k++)
      step(0, 2'b10, 0, 0, 32'h0, 5'h0);
    step(0, 2'b10, 1, 0, 32'h0, 5'h0);
    drain();

    // simultaneous push and pop at count 2
    step(0, 2'b01, 1, 0, 32'h0, 5'h0);
    step(0, 2'b01, 1, 0, 32'h0, 5'h0);
    step(0, 2'b10, 1, 1, 32'h2222, 5'h03);
    drain();

    // random traffic
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      bit g;
      bit rv;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          new_payload(i);
        end
      end
      g = $urandom_range(3) != 0;
      rv = q_m.size() > 0 && $urandom_range(2) == 0;
      step(0, pend, g, rv, $urandom, 5'($urandom));
      pend = pend & ~egnt_last;
    end
    drain();

    // stall counter: core1 blocked 5 cycles
    for (int k = 0; k < 5; k++)
      step(0, 2'b10, 0, 0, 32'h0, 5'h0);
    step(0, 2'b00, 0, 0, 32'h0, 5'h0);

    // response with nothing outstanding, then reset
    drain();
    step(0, 2'b00, 0, 1, 32'h5, 5'h0);
    step(0, 2'b00, 0, 0, 32'h0, 5'h0);
    step(1, 2'b00, 0, 0, 32'h0, 5'h0);
    step(0, 2'b01, 1, 0, 32'h0, 5'h0);
    step(0, 2'b00, 0, 1, 32'h7, 5'h04);
    step(0, 2'b00, 0, 0, 32'h0, 5'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_apu_arbiter.md
Name: cv32e40p_apu_arbiter

Overview:
- Shares one APU/FPU (cv32e40p_fp_wrapper) between NUM_REQ cores over the standard APU request/response interface.
- Issue uses round-robin arbitration.
- A requester-ID FIFO tracks outstanding operations and routes each response back to the core that issued it.
- Sits between the cores' apu_* ports and a single FPU instance in a shared-FPU cluster.

Parameters:
- NUM_REQ, 2: number of cores sharing the unit (2..8).
- MAX_OUTSTANDING, 4: ID FIFO depth, i.e. maximum in-flight operations (power of 2, ≥2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- core_req_i  in  NUM_REQ  per-core APU request
- core_gnt_o  out  NUM_REQ  per-core grant
- core_operands_i  in  NUM_REQ x APU_NARGS_CPU x 32  operands
- core_op_i  in  NUM_REQ x APU_WOP_CPU  opcode
- core_flags_i  in  NUM_REQ x APU_NDSFLAGS_CPU  downstream flags
- core_rvalid_o  out  NUM_REQ  per-core result valid
- core_result_o  out  32  result, broadcast to all cores
- core_rflags_o  out  APU_NUSFLAGS_CPU  result flags, broadcast
- apu_req_o  out  1  request to FPU
- apu_gnt_i  in  1  FPU grant
- apu_operands_o  out  APU_NARGS_CPU x 32  muxed operands
- apu_op_o  out  APU_WOP_CPU  muxed opcode
- apu_flags_o  out  APU_NDSFLAGS_CPU  muxed flags
- apu_rvalid_i  in  1  FPU result valid
- apu_result_i  in  32  FPU result
- apu_rflags_i  in  APU_NUSFLAGS_CPU  FPU flags
- err_o  out  1  sticky protocol error
- perf_stall_cnt_o  out  NUM_REQ x 32  per-core stall counters (see Optional Feature)

Behaviour:
- One clock (clk_i). rst_i is synchronous, active-high.
- Reset state: RR pointer=0, FIFO empty, err_o=0, counters=0.
- Reset affects registered state only. Outputs are combinational from that state and the inputs.
- Whenever rst_i=1: apu_req_o=0, core_gnt_o=0, core_rvalid_o=0.
- Issue eligibility: fifo_full=0.
- Selection: sel = first core with core_req_i=1, searching from RR pointer upward with wrap (pointer, pointer+1 ... NUM_REQ-1, 0 ...).
- Issue outputs: apu_req_o = eligible AND any core_req_i. apu_operands_o/op_o/flags_o = core[sel] fields. When apu_req_o=0 they carry core[pointer] fields (don't-care).
- Grant: core_gnt_o[sel] = apu_req_o AND apu_gnt_i, combinational, 0-cycle. All other grants are 0.
- Handshake (core_gnt_o[sel]=1):
  - push sel into ID FIFO
  - pointer <= (sel+1) mod NUM_REQ
- No handshake: pointer holds. The winner stays selected while its request is held, so the grant is never re-routed mid-request.
- Cores keep request and payload stable until granted (APU protocol). The arbiter does not check this.
- In-order contract: the FPU returns results in issue order (equal lane latency configuration). The FIFO head always names the owner of the next result.
- Response: on apu_rvalid_i=1 with FIFO not empty:
  - core_rvalid_o[head]=1 in the same cycle, combinational
  - core_result_o=apu_result_i, core_rflags_o=apu_rflags_i
  - pop FIFO
- Full: fifo_full=1 forces apu_req_o=0, even if a pop happens in the same cycle (full is decided on registered state). The FPU is never offered a request it could not track.
- Simultaneous push and pop when not full: both take effect; count unchanged.
- apu_rvalid_i=1 with FIFO empty: response dropped, core_rvalid_o=0, err_o<=1. err_o clears only on reset.
- FIFO pointers wrap modulo MAX_OUTSTANDING. Count width is clog2(MAX_OUTSTANDING)+1.
- Reset mid-operation: in-flight IDs are discarded. Later FPU responses set err_o, so the FPU must be reset together with the arbiter.

Optional Feature:
- Macro: CV32E40P_APU_ARB_PERF_EN.
- Defined: perf_stall_cnt_o[i] increments each cycle core_req_i[i]=1 AND core_gnt_o[i]=0. Saturates at 32'hFFFF_FFFF. Reset to 0.
- Undefined: perf_stall_cnt_o tied to 0 and no counter flops are built.

Decomposition:
- cv32e40p_apu_core_pkg: reuse APU_NARGS_CPU, APU_WOP_CPU, APU_NDSFLAGS_CPU, APU_NUSFLAGS_CPU.
- Add to the same package: APU_ARB_MAX_REQ=8 and a typedef for the requester-ID width.
- Sub-module cv32e40p_apu_arb_id_fifo: synchronous FIFO of IDs, parameters DEPTH and WIDTH, outputs full, empty and head.

Test Plan:
- Single core: core0 req, apu_gnt_i=1 → core_gnt_o=01, apu_op_o=core0 op. Later rvalid with result 0x3F80_0000 → core_rvalid_o=01, core_result_o=0x3F80_0000.
- Fairness: both cores request continuously, apu_gnt_i=1 → grants alternate 01,10,01,10; pointer toggles each cycle.
- Backpressure: apu_gnt_i=0 for 3 cycles with core1 requesting → core_gnt_o=00 for those cycles. Selection stays on core1; core1 is granted on the first cycle apu_gnt_i=1.
- Full: MAX_OUTSTANDING=4, issue 4 ops with no rvalid → apu_req_o=0 on the 5th cycle. Single rvalid → issue resumes the next cycle. Responses route in order, e.g. 0,1,0,1.
- Simultaneous: count=2, push core1 and pop core0 in the same cycle → core_rvalid_o=01, count stays 2, new tail ID=1.
- Error/reset: rvalid with FIFO empty → err_o=1 next cycle. rst_i=1 for 1 cycle → err_o=0, FIFO empty. With CV32E40P_APU_ARB_PERF_EN: core1 blocked 5 cycles → perf_stall_cnt_o[1]=5.
